// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Purpose  : Shared types, defaults and helpers for the divided-clock
//             period checker (state encoding, default counter width and
//             the tolerance compare).
//  Revision : 1.0  initial release
// ============================================================================
package clk_div_pkg;

   // Default width of the period counter and the period/expected fields.
   localparam int CNT_W_DEFAULT = 8;

   // Checker state. The encoding is visible on the debug port, so the
   // numeric values are fixed.
   typedef enum logic [1:0] {
      CDC_IDLE      = 2'd0,
      CDC_WAIT_EDGE = 2'd1,
      CDC_ACQUIRE   = 2'd2,
      CDC_LOCKED    = 2'd3
   } cdc_state_t;

   // True when |period - expected| <= tol. The subtraction is done one bit
   // wider than the operands so that neither operand order can wrap.
   function automatic logic period_match(input logic [31:0] period,
                                         input logic [31:0] expected,
                                         input logic [31:0] tol);
      logic [32:0] diff;
      if (period >= expected)
         diff = {1'b0, period} - {1'b0, expected};
      else
         diff = {1'b0, expected} - {1'b0, period};
      return (diff <= {1'b0, tol});
   endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/div_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module   : div_edge_detect
//  Purpose  : Samples the divided clock under test and produces a one-cycle
//             pulse for every rising edge seen in the clk domain.
//             CLK_DIV_CHECK_SYNC_EN defined   : 2-flop synchronizer before
//                                               the edge compare (async input).
//             CLK_DIV_CHECK_SYNC_EN undefined : single sampling register
//                                               (input synchronous to clk).
//  Revision : 1.0  initial release
// ============================================================================
module div_edge_detect (
   input  logic clk,
   input  logic reset,
   input  logic div_in,
   output logic div_edge
);

   // Value of div_in as seen in the clk domain, and its previous cycle.
   logic sampled;
   logic prev;

`ifdef CLK_DIV_CHECK_SYNC_EN
   // First synchronizer stage; may go metastable, never used directly.
   logic sync_meta;

   // Two-flop synchronizer: div_in may be unrelated to clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b0;
         sampled   <= 1'b0;
      end else begin
         sync_meta <= div_in;
         sampled   <= sync_meta;
      end
   end
`else
   // Single sampling register: div_in is already synchronous to clk.
   always_ff @(posedge clk) begin
      if (reset)
         sampled <= 1'b0;
      else
         sampled <= div_in;
   end
`endif

   // Delayed copy of the sampled level for the rising-edge compare.
   always_ff @(posedge clk) begin
      if (reset)
         prev <= 1'b0;
      else
         prev <= sampled;
   end

   // High for exactly one cycle when the sampled level goes 0 -> 1.
   assign div_edge = sampled & ~prev;

endmodule : div_edge_detect
`default_nettype wire

// File: rtl/clk_div_checker.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_checker
//  Purpose  : Measures the rising-edge-to-rising-edge period of a divided
//             clock in clk cycles, compares it with expected_period (within
//             TOL), declares lock after LOCK_COUNT consecutive matches and
//             raises a sticky error on any mismatch once locked.
//             Build option: CLK_DIV_CHECK_SYNC_EN (adds an input
//             synchronizer inside div_edge_detect, one extra cycle latency).
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_checker
   import clk_div_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEFAULT,
   parameter int LOCK_COUNT = 4,
   parameter int TOL        = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_in,
   input  logic [CNT_W-1:0] expected_period,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             locked,
   output logic             error,
   output logic [1:0]       state
);

   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [3:0]       LOCK_VAL = 4'(LOCK_COUNT);

   cdc_state_t       fsm_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [3:0]       match_cnt;
   logic [3:0]       match_next;
   logic             div_edge;
   logic             timeout;
   logic             measure;
   logic             is_match;

   // Sampler / synchronizer and rising-edge detector.
   div_edge_detect u_edge (
      .clk      (clk),
      .reset    (reset),
      .div_in   (div_in),
      .div_edge (div_edge)
   );

   // A saturated counter with no edge is a missing edge; an edge arriving in
   // the same cycle wins and is measured normally.
   assign timeout  = (cnt == CNT_MAX) && !div_edge;
   assign measure  = div_edge || timeout;
   assign cnt_inc  = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);

   // A timeout is always a mismatch, whatever expected_period says.
   assign is_match   = div_edge &&
                       period_match(32'(cnt), 32'(expected_period), 32'(TOL));
   assign match_next = match_cnt + 4'd1;

   assign state = fsm_state;

   // Checker FSM with the period counter and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_state    <= CDC_IDLE;
         cnt          <= '0;
         match_cnt    <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         error        <= 1'b0;
      end else if (!enable) begin
         // Drop everything except the last reported period.
         fsm_state    <= CDC_IDLE;
         cnt          <= '0;
         match_cnt    <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         error        <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         case (fsm_state)
            CDC_IDLE: begin
               cnt       <= '0;
               match_cnt <= '0;
               fsm_state <= CDC_WAIT_EDGE;
            end

            CDC_WAIT_EDGE: begin
               // The first edge only opens a measurement window; timeouts
               // here are silent because there is nothing to measure yet.
               if (div_edge) begin
                  cnt       <= CNT_ONE;
                  fsm_state <= CDC_ACQUIRE;
               end else if (timeout) begin
                  cnt <= CNT_ONE;
               end else begin
                  cnt <= cnt_inc;
               end
            end

            CDC_ACQUIRE: begin
               if (measure) begin
                  cnt          <= CNT_ONE;
                  period_out   <= cnt;
                  period_valid <= 1'b1;
                  if (is_match) begin
                     match_cnt <= match_next;
                     if (match_next == LOCK_VAL) begin
                        fsm_state <= CDC_LOCKED;
                        locked    <= 1'b1;
                     end
                  end else begin
                     match_cnt <= '0;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end

            CDC_LOCKED: begin
               if (measure) begin
                  cnt          <= CNT_ONE;
                  period_out   <= cnt;
                  period_valid <= 1'b1;
                  if (!is_match) begin
                     // Lost lock: error stays set until enable/reset.
                     error     <= 1'b1;
                     locked    <= 1'b0;
                     match_cnt <= '0;
                     fsm_state <= CDC_ACQUIRE;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end

            default: fsm_state <= CDC_IDLE;
         endcase
      end
   end

endmodule : clk_div_checker
`default_nettype wire

// File: tb/tb_clk_div_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_checker
//  Purpose  : Self-checking bench for clk_div_checker. Two instances
//             (TOL=0 and TOL=1) see the same div_in; a period-level
//             reference model predicts every report into per-instance
//             queues and a negedge monitor compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_checker;

`ifdef CLK_DIV_CHECK_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif
   localparam int MAXP  = 255;
   localparam int LOCKN = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       div_in = 1'b0;
   logic [7:0] expected_period = 8'd16;

   logic [7:0] po0, po1;
   logic       pv0, pv1, lk0, lk1, er0, er1;
   logic [1:0] st0, st1;

   always #5 clk = ~clk;

   clk_div_checker #(.CNT_W(8), .LOCK_COUNT(LOCKN), .TOL(0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .div_in(div_in),
      .expected_period(expected_period), .period_out(po0),
      .period_valid(pv0), .locked(lk0), .error(er0), .state(st0));

   clk_div_checker #(.CNT_W(8), .LOCK_COUNT(LOCKN), .TOL(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .div_in(div_in),
      .expected_period(expected_period), .period_out(po1),
      .period_valid(pv1), .locked(lk1), .error(er1), .state(st1));

   int checks = 0;
   int failures = 0;

   typedef struct {
      int per;
      bit lk;
      bit er;
   } exp_t;
   exp_t q0[$];
   exp_t q1[$];

   // Reference model, one set per instance (index = tolerance)
   int  mstate [2];   // 0 idle, 1 wait first edge, 2 acquire, 3 locked
   int  mlast  [2];   // cycle of last rising edge / timeout
   int  mstreak[2];
   bit  mlocked[2];
   bit  merr   [2];
   int  mper   [2];
   bit  hist[0:3];
   int  cyc = 0;
   bit  mon_on = 1'b0;

   task automatic model_step(input int i, input bit rise, input int q, input int expv);
      int  p;
      int  d;
      bit  ok;
      exp_t e;
      if (reset) begin
         mstate[i] = 0; mstreak[i] = 0; mlocked[i] = 0; merr[i] = 0; mper[i] = 0;
      end else if (!enable) begin
         mstate[i] = 0; mstreak[i] = 0; mlocked[i] = 0; merr[i] = 0;
      end else if (mstate[i] == 0) begin
         mstate[i] = 1;
      end else if (mstate[i] == 1) begin
         if (rise) begin
            mstate[i] = 2;
            mlast[i] = q;
         end
      end else begin
         p = -1;
         if (rise) p = q - mlast[i];
         else if (q - mlast[i] == MAXP) p = MAXP;
         if (p >= 0) begin
            mlast[i] = q;
            d = p - expv;
            if (d < 0) d = -d;
            ok = rise && (d <= i);
            if (mstate[i] == 2) begin
               if (ok) begin
                  mstreak[i]++;
                  if (mstreak[i] == LOCKN) begin
                     mstate[i] = 3;
                     mlocked[i] = 1;
                  end
               end else begin
                  mstreak[i] = 0;
               end
            end else if (!ok) begin
               merr[i] = 1; mlocked[i] = 0; mstreak[i] = 0; mstate[i] = 2;
            end
            mper[i] = p;
            e.per = p; e.lk = mlocked[i]; e.er = merr[i];
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
         end
      end
   endtask

   // Model advances on each active edge from the bench's own view of div_in
   always @(posedge clk) begin
      bit rise;
      cyc++;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = div_in;
      rise = hist[LAT] && !hist[LAT+1];
      if (reset) mon_on = 1'b1;
      for (int i = 0; i < 2; i++) model_step(i, rise, cyc, int'(expected_period));
   end

   task automatic check_dut(input int i, input logic [7:0] po, input logic pv,
                            input logic lk, input logic er, input logic [1:0] st);
      exp_t e;
      checks++;
      if (po !== 8'(mper[i]) || lk !== mlocked[i] || er !== merr[i] || st !== 2'(mstate[i])) begin
         failures++;
         $display("FAIL outputs dut%0d t=%0t got per=%0d lk=%b er=%b st=%0d want per=%0d lk=%b er=%b st=%0d",
                  i, $time, po, lk, er, st, mper[i], mlocked[i], merr[i], mstate[i]);
      end
      if (pv === 1'b1) begin
         checks++;
         if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL spurious_valid dut%0d t=%0t got valid=1 want no report", i, $time);
         end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            if (po !== 8'(e.per) || lk !== e.lk || er !== e.er) begin
               failures++;
               $display("FAIL report dut%0d t=%0t got per=%0d lk=%b er=%b want per=%0d lk=%b er=%b",
                        i, $time, po, lk, er, e.per, e.lk, e.er);
            end
         end
      end else if (pv !== 1'b0) begin
         checks++;
         failures++;
         $display("FAIL valid_x dut%0d t=%0t got %b want 0/1", i, $time, pv);
      end
   endtask

   // Monitor: compare away from the active edge
   always @(negedge clk) begin
      if (mon_on) begin
         check_dut(0, po0, pv0, lk0, er0, st0);
         check_dut(1, po1, pv1, lk1, er1, st1);
      end
   end

   task automatic cyc1();
      @(posedge clk);
      #1;
   endtask

   // One period p of div_in, high for h cycles
   task automatic wave(input int p, input int h);
      for (int c = 0; c < p; c++) begin
         div_in = (c < h);
         cyc1();
      end
   endtask

   task automatic sq(input int p, input int n);
      repeat (n) wave(p, p / 2);
   endtask

   task automatic do_reset();
      div_in = 1'b0;
      reset = 1'b1;
      repeat (3) cyc1();
      checks++;
      if ({po0, pv0, lk0, er0, st0} !== 13'd0 || {po1, pv1, lk1, er1, st1} !== 13'd0) begin
         failures++;
         $display("FAIL reset_values got dut0=%h dut1=%h want 0",
                  {po0, pv0, lk0, er0, st0}, {po1, pv1, lk1, er1, st1});
      end
      reset = 1'b0;
      repeat (2) cyc1();
   endtask

   initial begin
      int p, h, r;
      do_reset();
      enable = 1'b1;
      expected_period = 8'd16;
      // div16 tap: lock on the 4th report
      sq(16, 8);
      // period shrinks to 12 -> error, then relock on expected 12
      sq(12, 6);
      expected_period = 8'd12;
      sq(12, 6);
      // 15/17 alternation, then 18, then back to 16
      expected_period = 8'd16;
      repeat (3) begin
         wave(15, 7);
         wave(17, 8);
      end
      wave(18, 9);
      sq(16, 6);
      // stuck low after lock: timeout reports every 255 cycles
      div_in = 1'b0;
      repeat (600) cyc1();
      sq(16, 6);
      // enable drop mid-acquire
      sq(16, 2);
      div_in = 1'b0;
      enable = 1'b0;
      repeat (3) cyc1();
      enable = 1'b1;
      sq(16, 6);
      // reset mid-measurement
      sq(16, 2);
      wave(10, 5);
      do_reset();
      sq(16, 6);
      // randomized periods, expected values and enable drops
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(99, 0);
         if (r < 35)      p = int'(expected_period) + $urandom_range(2, 0) - 1;
         else if (r < 40) p = $urandom_range(300, 250);
         else             p = $urandom_range(40, 2);
         h = $urandom_range(p - 1, 1);
         wave(p, h);
         r = $urandom_range(99, 0);
         if (r < 6) begin
            div_in = 1'b0;
            enable = 1'b0;
            repeat ($urandom_range(4, 1)) cyc1();
            enable = 1'b1;
         end else if (r < 14) begin
            case ($urandom_range(3, 0))
               0: expected_period = 8'd8;
               1: expected_period = 8'd12;
               2: expected_period = 8'd16;
               default: expected_period = 8'd20;
            endcase
         end
      end
      div_in = 1'b0;
      repeat (6) cyc1();
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         failures++;
         $display("FAIL missing_reports got pending dut0=%0d dut1=%0d want 0", q0.size(), q1.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_clk_div_checker
`default_nettype wire

// File: doc/clk_div_checker.md
# clk_div_checker

Measures the period of an incoming divided-clock signal, such as a divide-by-2/4/8/16 tap from the team's binary counter, in units of the fast clock `clk`. It compares each measured period against an expected value and reports lock or a sticky error. It sits downstream of the clock-divider logic as a self-check and bring-up monitor.

## Interface
- `CNT_W`, 8, width of the period counter and the period/expected fields.
- `LOCK_COUNT`, 4, consecutive matching periods required to declare lock (1..15).
- `TOL`, 0, allowed absolute deviation in clk cycles for a period to count as a match.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  checker run; low forces IDLE.
- `div_in`  in  1  divided-clock signal under test; may be asynchronous when `CLK_DIV_CHECK_SYNC_EN` is defined.
- `expected_period`  in  CNT_W  expected rising-edge-to-rising-edge period in clk cycles.
- `period_out`  out  CNT_W  last measured period.
- `period_valid`  out  1  one-cycle pulse when `period_out` updates.
- `locked`  out  1  high in LOCKED state.
- `error`  out  1  sticky mismatch-after-lock flag.
- `state`  out  2  FSM state, for debug.

## Operation
- Input path: `div_in` → sampler (see Configuration) → `prev` register. Rising edge (`edge`) = sampled & ~prev.
- Period counter `cnt`:
  - loads 1 on an edge cycle;
  - otherwise increments, saturating at 2^CNT_W−1.
  - Measured period = `cnt` value in the edge cycle. A square wave toggling every 8 clk therefore measures 16.
- Timeout: `cnt` == 2^CNT_W−1 with no edge:
  - treated as a measurement of 2^CNT_W−1;
  - counts as a mismatch;
  - `cnt` reloads 1.
- Match: |period − expected_period| ≤ TOL, computed at CNT_W+1 bits. `expected_period` is sampled at each compare; a change does not restart the FSM.
- FSM, encoded IDLE=0, WAIT_EDGE=1, ACQUIRE=2, LOCKED=3. `error` is a separate flag, valid in LOCKED/ACQUIRE:
  - IDLE: `cnt` = 0, `match_cnt` = 0. `enable` → WAIT_EDGE.
  - WAIT_EDGE: first edge loads `cnt` = 1, no `period_valid`, → ACQUIRE. A timeout here stays in WAIT_EDGE with no report.
  - ACQUIRE: each measurement pulses `period_valid`.
    - Match: `match_cnt`++; on reaching LOCK_COUNT → LOCKED.
    - Mismatch: `match_cnt` = 0, stay.
  - LOCKED: match stays. Mismatch (including timeout) sets `error`, clears `locked` and `match_cnt`, → ACQUIRE.
- `error` stays set until `enable` low or `reset`. A re-lock does not clear it.
- `enable` low in any state: next cycle IDLE; `locked`, `error`, `match_cnt`, `cnt` cleared. `period_out` holds.

## Timing
- Reset values: `period_out` = 0, `period_valid` = 0, `locked` = 0, `error` = 0, `state` = IDLE.
- Reset mid-measurement discards the partial count. The first edge after reset only starts a measurement.
- Latency with sync: `period_valid`, `period_out`, `locked` and `error` update on the clk edge 2 cycles after the edge that first samples `div_in` high. The sync register, then the `prev` compare, then the output register.
- Latency without sync: 1 cycle.
- `locked` rises on the same edge as the `period_valid` of the LOCK_COUNT-th match. `error` rises with the `period_valid` of the failing measurement.
- An edge and a timeout in the same cycle count as an edge only.
- `div_in` high pulses shorter than one clk may be missed; no requirement on them.

## Configuration
- `CLK_DIV_CHECK_SYNC_EN` defined: `div_in` passes a 2-flop synchronizer before `prev`. Latency as above.
- `CLK_DIV_CHECK_SYNC_EN` undefined: a single register samples `div_in`. The input is required to be synchronous to `clk`. Latency is one cycle less.

## Structure
- Shared package `clk_div_pkg`:
  - state enum (`CDC_IDLE`, `CDC_WAIT_EDGE`, `CDC_ACQUIRE`, `CDC_LOCKED`);
  - default `CNT_W`;
  - function `period_match(period, expected, tol)`.
- One sub-module, `div_edge_detect`: sampler/synchronizer plus `prev` register, outputting a one-cycle `edge`. It contains the `CLK_DIV_CHECK_SYNC_EN` ifdef.
- FSM, counter and compare stay in the top.

## Test plan
- Reference counter div16 tap (toggle every 8 clk), expected=16, TOL=0, enable → first `period_valid` at the second rising edge with `period_out` = 16; `locked` = 1 on the 4th valid; `error` = 0.
- Locked on 16, then the input period changes to 12 → next `period_valid` shows 12; `error` = 1, `locked` = 0, `state` = ACQUIRE. After 4 periods with expected changed to 12 → `locked` = 1, `error` still 1.
- TOL=1, expected=16, periods alternating 15/17 → lock after 4; period 18 → `error`.
- CNT_W=8, `div_in` stuck low after lock → after 255 cycles without an edge, `period_valid` with `period_out` = 255, `error` = 1; repeats every 255 cycles.
- `reset` or `enable` low mid-ACQUIRE → outputs at reset values (`period_out` held on enable drop); the next measurement needs two fresh edges.
- Latency check with and without `CLK_DIV_CHECK_SYNC_EN`: `period_valid` appears 2 cycles (sync) or 1 cycle (no sync) after the sample edge.
